gobou_sched: RTL

- Layer sequencer for the gobou fully-connected engine.
- On a host request it walks the output neurons in groups of CORE. For each group it:
  - streams input pixels from the image memory and weights from the per-core net memories;
  - triggers accumulate, bias and clear on the cores;
  - serialises the CORE results back into the image memory.
- Sits between the host request/ack interface and the mem_img, mem_net, core and serial_vec instances.

---
 rtl/gobou_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gobou_sched.sv
// Layer sequencer for the gobou fully-connected engine: walks output groups of CORE neurons,
// drives memory addresses and core/serializer strobes. Optional macro: GOBOU_SCHED_PERF_EN.
module gobou_sched #(
   parameter int DWIDTH   = 16,
   parameter int IMGSIZE  = 12,
   parameter int NETSIZE  = 14,
   parameter int LWIDTH   = 10,
   parameter int CORE     = 8,
   parameter int CORELOG  = 3,
   parameter int CORE_LAT = 3
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               req,
   input  logic [LWIDTH-1:0]  total_in,
   input  logic [LWIDTH-1:0]  total_out,
   input  logic [IMGSIZE-1:0] input_addr,
   input  logic [IMGSIZE-1:0] output_addr,
   output logic               ack,
   output logic               mem_img_we,
   output logic [IMGSIZE-1:0] mem_img_addr,
   output logic [NETSIZE-1:0] mem_net_addr,
   output logic               core_clr,
   output logic               core_acc,
   output logic               core_bias,
   output logic               serial_load,
`ifdef GOBOU_SCHED_PERF_EN
   output logic               serial_shift,
   output logic [31:0]        busy_cycles
`else
   output logic               serial_shift
`endif
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StBias  = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StSload = 3'd4;
   localparam logic [2:0] StStore = 3'd5;
   localparam logic [2:0] StDone  = 3'd6;

   localparam logic [LWIDTH-1:0] CoreL     = LWIDTH'(CORE);
   localparam logic [LWIDTH-1:0] DrainLast = LWIDTH'(CORE_LAT - 1);

   logic [2:0]         state;
   logic [LWIDTH-1:0]  cnt;
   logic [LWIDTH-1:0]  ti;
   logic [LWIDTH-1:0]  rem;
   logic [IMGSIZE-1:0] in_base;
   logic [IMGSIZE-1:0] out_base;
   logic [NETSIZE-1:0] net_base;
   logic               acc_q;
   logic               bias_q;
   logic [LWIDTH-1:0]  n_grp;

   // rem >= CORE exactly when any bit above the low CORELOG bits is set
   assign n_grp = (rem[LWIDTH-1:CORELOG] != '0) ? CoreL : rem;

   always_ff @(posedge clk) begin
      if (xrst) begin
         state    <= StIdle;
         cnt      <= '0;
         ti       <= '0;
         rem      <= '0;
         in_base  <= '0;
         out_base <= '0;
         net_base <= '0;
         acc_q    <= 1'b0;
         bias_q   <= 1'b0;
      end else begin
         acc_q  <= (state == StLoad);
         bias_q <= (state == StBias);
         case (state)
            StIdle: begin
               if (req) begin
                  ti       <= total_in;
                  rem      <= total_out;
                  in_base  <= input_addr;
                  out_base <= output_addr;
                  net_base <= '0;
                  cnt      <= '0;
                  state    <= (total_in == '0 || total_out == '0) ? StDone : StLoad;
               end
            end
            StLoad: begin
               if (cnt == ti - 1'b1) begin
                  cnt   <= '0;
                  state <= StBias;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StBias: begin
               cnt   <= '0;
               state <= StDrain;
            end
            StDrain: begin
               if (cnt == DrainLast) begin
                  cnt   <= '0;
                  state <= StSload;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StSload: begin
               cnt   <= '0;
               state <= StStore;
            end
            StStore: begin
               if (cnt == n_grp - 1'b1) begin
                  cnt <= '0;
                  if (rem > CoreL) begin
                     rem      <= rem - CoreL;
                     out_base <= out_base + IMGSIZE'(CORE);
                     net_base <= net_base + NETSIZE'(ti) + NETSIZE'(1);
                     state    <= StLoad;
                  end else begin
                     state <= StDone;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      ack          = 1'b0;
      mem_img_we   = 1'b0;
      mem_img_addr = '0;
      mem_net_addr = '0;
      core_clr     = 1'b0;
      serial_load  = 1'b0;
      serial_shift = 1'b0;
      case (state)
         StLoad: begin
            mem_img_addr = in_base + IMGSIZE'(cnt);
            mem_net_addr = net_base + NETSIZE'(cnt);
            core_clr     = (cnt == '0);
         end
         StBias:  mem_net_addr = net_base + NETSIZE'(ti);
         StSload: serial_load = 1'b1;
         StStore: begin
            mem_img_we   = 1'b1;
            mem_img_addr = out_base + IMGSIZE'(cnt);
            serial_shift = 1'b1;
         end
         StDone:  ack = 1'b1;
         default: ;
      endcase
   end

   // Read data arrives one cycle after the address, so accumulate/bias trail it
   assign core_acc  = acc_q;
   assign core_bias = bias_q;

`ifdef GOBOU_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (xrst) begin
         busy_cycles <= '0;
      end else if (state == StIdle) begin
         if (req) busy_cycles <= '0;
      end else if (busy_cycles != '1) begin
         busy_cycles <= busy_cycles + 32'd1;
      end
   end
`endif

endmodule
